// File: rtl/despachante_clusters_pkg.sv
// Shared types and defaults for the cluster dispatcher that drains the
// pending-lookup buffer.
package despachante_clusters_pkg;

   typedef enum logic [1:0] {
      OCIOSO,   // waiting for a head entry
      ENVIA,    // presenting a probe to the lowest pending cluster
      ESPERA,   // one probe outstanding, waiting for its answer
      RETIRA    // retiring the entry and reporting the result
   } estado_t;

   localparam int NUM_CLUSTERS_PADRAO  = 5;
   localparam int TAM_ENDERECO_PADRAO  = 64;
   localparam int TAM_HASH_DOIS_PADRAO = 8;
   localparam int TIMEOUT_PADRAO       = 15;

   // Index width for n targets; never narrower than one bit.
   function automatic int tam_idx(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/despachante_clusters_seletor_menor_bit.sv
// Lowest-set-bit finder: returns the index of the lowest set bit of a
// vector and whether any bit is set. Mirrors the buffer's priority encoder.
module seletor_menor_bit
   import despachante_clusters_pkg::*;
#(
   parameter int LARGURA = NUM_CLUSTERS_PADRAO,
   parameter int TAM_IDX = tam_idx(LARGURA)
) (
   input  logic [LARGURA-1:0] vetor,
   output logic [TAM_IDX-1:0] indice,
   output logic               nao_zero
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      indice   = '0;
      nao_zero = |vetor;
      for (int i = LARGURA - 1; i >= 0; i--) begin
         if (vetor[i]) indice = TAM_IDX'(i);
      end
   end

endmodule

// File: rtl/despachante_clusters.sv
// Consumer end of the pending-lookup buffer: captures the head entry, probes
// its candidate clusters lowest-first, one probe at a time, and retires the
// entry on the first hit or once every candidate has missed or timed out.
module despachante_clusters
   import despachante_clusters_pkg::*;
#(
   parameter int NUM_CLUSTERS  = NUM_CLUSTERS_PADRAO,
   parameter int TAM_ENDERECO  = TAM_ENDERECO_PADRAO,
   parameter int TAM_HASH_DOIS = TAM_HASH_DOIS_PADRAO,
   parameter int TIMEOUT       = TIMEOUT_PADRAO,
   parameter int TAM_IDX       = tam_idx(NUM_CLUSTERS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     entrada_valida,
   input  logic [NUM_CLUSTERS-1:0]  bitmap_atual,
   input  logic [TAM_ENDERECO-1:0]  endereco_atual,
   input  logic [TAM_HASH_DOIS-1:0] hash_atual,
   output logic [NUM_CLUSTERS-1:0]  bitmap_atualizado,
   output logic                     zero,
   output logic                     req_valido,
   input  logic                     req_pronto,
   output logic [TAM_IDX-1:0]       req_cluster,
   output logic [TAM_ENDERECO-1:0]  req_endereco,
   output logic [TAM_HASH_DOIS-1:0] req_hash,
   input  logic                     resp_valida,
   input  logic                     resp_acerto,
   output logic                     result_valido,
   output logic                     result_acerto,
   output logic [TAM_IDX-1:0]       result_cluster,
   output logic [TAM_ENDERECO-1:0]  result_endereco
);

   localparam int                   TAM_CONT = $clog2(TIMEOUT + 1);
   // The counter starts at 0 on the first waiting cycle, so the last
   // waiting cycle is the one where it holds TIMEOUT-1.
   localparam logic [TAM_CONT-1:0] LIMITE   = TAM_CONT'(TIMEOUT - 1);

   estado_t                  estado, proximo;
   logic [NUM_CLUSTERS-1:0]  bitmap_w;
   logic [TAM_ENDERECO-1:0]  endereco_w;
   logic [TAM_HASH_DOIS-1:0] hash_w;
   logic                     acerto_w;
   logic [TAM_IDX-1:0]       cluster_w;
   logic [TAM_CONT-1:0]      cont;

   logic [TAM_IDX-1:0]       idx_alvo;
   logic                     nao_zero;
   logic [NUM_CLUSTERS-1:0]  mascara_alvo;
   logic [NUM_CLUSTERS-1:0]  bitmap_restante;
   logic                     estourou;

   // While idle the buffer sees its own bitmap back, making its write-back a
   // no-op; afterwards it tracks the working copy. The selector shares this
   // view, so in OCIOSO it tells whether the incoming bitmap is empty.
   assign bitmap_atualizado = (estado == OCIOSO) ? bitmap_atual : bitmap_w;

   seletor_menor_bit #(
      .LARGURA (NUM_CLUSTERS),
      .TAM_IDX (TAM_IDX)
   ) u_seletor (
      .vetor    (bitmap_atualizado),
      .indice   (idx_alvo),
      .nao_zero (nao_zero)
   );

   assign mascara_alvo    = NUM_CLUSTERS'(1) << idx_alvo;
   assign bitmap_restante = bitmap_w & ~mascara_alvo;
   assign estourou        = (cont == LIMITE);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) estado <= OCIOSO;
      else     estado <= proximo;
   end

   // Next-state logic; a response arriving on the timeout cycle takes priority.
   always_comb begin
      proximo = estado;
      case (estado)
         OCIOSO: if (entrada_valida) proximo = nao_zero ? ENVIA : RETIRA;
         ENVIA:  if (req_pronto) proximo = ESPERA;
         ESPERA: begin
            if (resp_valida && resp_acerto)  proximo = RETIRA;
            else if (resp_valida || estourou) proximo = (|bitmap_restante) ? ENVIA : RETIRA;
         end
         RETIRA: proximo = OCIOSO;
         default: proximo = OCIOSO;
      endcase
   end

   // Working registers: entry capture, wait counter, bit clearing and hit record.
   always_ff @(posedge clk) begin
      if (rst) begin
         bitmap_w   <= '0;
         endereco_w <= '0;
         hash_w     <= '0;
         acerto_w   <= 1'b0;
         cluster_w  <= '0;
         cont       <= '0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (entrada_valida) begin
                  bitmap_w   <= bitmap_atual;
                  endereco_w <= endereco_atual;
                  hash_w     <= hash_atual;
                  acerto_w   <= 1'b0;
                  cluster_w  <= '0;
               end
            end
            ENVIA: if (req_pronto) cont <= '0;
            ESPERA: begin
               cont <= cont + 1'b1;
               if (resp_valida && resp_acerto) begin
                  acerto_w  <= 1'b1;
                  cluster_w <= idx_alvo;
               end else if (resp_valida || estourou) begin
                  bitmap_w <= bitmap_restante;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are decoded from the state; everything idles at zero.
   always_comb begin
      zero            = 1'b0;
      req_valido      = 1'b0;
      req_cluster     = '0;
      req_endereco    = '0;
      req_hash        = '0;
      result_valido   = 1'b0;
      result_acerto   = 1'b0;
      result_cluster  = '0;
      result_endereco = '0;
      case (estado)
         ENVIA: begin
            req_valido   = 1'b1;
            req_cluster  = idx_alvo;
            req_endereco = endereco_w;
            req_hash     = hash_w;
         end
         RETIRA: begin
            zero            = 1'b1;
            result_valido   = 1'b1;
            result_acerto   = acerto_w;
            result_cluster  = cluster_w;
            result_endereco = endereco_w;
         end
         default: ;
      endcase
   end

endmodule
